// File: rtl/sdram_host_arbiter.sv
// Two-port arbiter in front of the SDRAM controller host port: grants one requester,
// issues a single command pulse, tracks completion/timeout. Define SDRAM_ARB_RR_EN for round-robin.
`timescale 1ns/1ps
module sdram_host_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              arb_err,
  output logic              host_wr_req,
  output logic              host_rd_req,
  output logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_data_in,
  input  logic [DATA_W-1:0] host_data_out,
  input  logic              host_busy,
  input  logic              host_rd_valid,
  output logic              grant
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACCEPT, S_DONE} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t              state_q;
  logic                we_q;
  logic [7:0]          cnt_q;
  logic                grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   p0_rdata_q, p1_rdata_q;
  logic                p0_ack_q, p1_ack_q, arb_err_q;
  logic                wr_req_q, rd_req_q;

  logic                start_d, win_d, active_d, rd_fin_d, wr_fin_d, fin_d, tmo_d;

  always_comb begin
    // The ack cycle is skipped so a requester dropping req after its ack is not re-granted.
    start_d  = (p0_req || p1_req) && !host_busy && !(p0_ack_q || p1_ack_q);
`ifdef SDRAM_ARB_RR_EN
    if (p0_req && p1_req) win_d = ~grant_q;
    else                  win_d = p1_req;
`else
    win_d    = !p0_req;
`endif
    active_d = (state_q == S_ACCEPT) || (state_q == S_DONE);
    rd_fin_d = active_d && !we_q && host_rd_valid;
    wr_fin_d = (state_q == S_DONE) && we_q && !host_busy;
    fin_d    = rd_fin_d || wr_fin_d;
    tmo_d    = active_d && !fin_d && (cnt_q >= TMO);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      arb_err_q  <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      p0_ack_q  <= 1'b0;
      p1_ack_q  <= 1'b0;
      arb_err_q <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            grant_q <= win_d;
            we_q    <= win_d ? p1_we    : p0_we;
            addr_q  <= win_d ? p1_addr  : p0_addr;
            wdata_q <= win_d ? p1_wdata : p0_wdata;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wr_req_q <= we_q;
          rd_req_q <= !we_q;
          cnt_q    <= '0;
          state_q  <= S_ACCEPT;
        end
        S_ACCEPT, S_DONE: begin
          if (fin_d || tmo_d) begin
            p0_ack_q  <= !grant_q;
            p1_ack_q  <= grant_q;
            arb_err_q <= tmo_d;
            if (rd_fin_d) begin
              if (grant_q) p1_rdata_q <= host_data_out;
              else         p0_rdata_q <= host_data_out;
            end
            state_q <= S_IDLE;
          end else if ((state_q == S_ACCEPT) && host_busy) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p0_ack       = p0_ack_q;
  assign p1_ack       = p1_ack_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign arb_err      = arb_err_q;
  assign host_wr_req  = wr_req_q;
  assign host_rd_req  = rd_req_q;
  assign host_addr    = addr_q;
  assign host_data_in = wdata_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter; the SDRAM controller side is driven inline by each test.
`timescale 1ns/1ps
module tb_sdram_host_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ack, p1_ack, arb_err, host_wr_req, host_rd_req, grant;
  logic [DW-1:0] p0_rdata, p1_rdata, host_data_in;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data_out = '0;
  logic          host_busy = 1'b0, host_rd_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rd = 0, n_ack0 = 0, n_ack1 = 0, n_err = 0, n_both = 0;
  logic [DW-1:0] exp_rd0, exp_rd1;

  sdram_host_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .arb_err(arb_err), .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
    .host_addr(host_addr), .host_data_in(host_data_in), .host_data_out(host_data_out),
    .host_busy(host_busy), .host_rd_valid(host_rd_valid), .grant(grant)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    n_wr   <= n_wr   + (host_wr_req ? 1 : 0);
    n_rd   <= n_rd   + (host_rd_req ? 1 : 0);
    n_ack0 <= n_ack0 + (p0_ack ? 1 : 0);
    n_ack1 <= n_ack1 + (p1_ack ? 1 : 0);
    n_err  <= n_err  + (arb_err ? 1 : 0);
    n_both <= n_both + ((p0_ack && p1_ack) ? 1 : 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_cmd(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      tick();
      n++;
      if (host_wr_req || host_rd_req) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({p0_ack, p1_ack, arb_err, host_wr_req, host_rd_req, grant} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {p0_ack, p1_ack, arb_err, host_wr_req, host_rd_req, grant});
    end
    checks++;
    if (p0_rdata !== 16'h0 || p1_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0000/0000", p0_rdata, p1_rdata);
    end
    checks++;
    if (host_addr !== 24'h0 || host_data_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_host: got addr %h data %h want 0/0", host_addr, host_data_in);
    end
    rst = 1'b0;
    exp_rd0 = 16'h0;
    exp_rd1 = 16'h0;
    tick();
  endtask

  task automatic test_write_p1();
    int a0, a1, w, n;
    bit ok;
    a0 = n_ack0; a1 = n_ack1; w = n_wr;
    p1_we = 1'b1; p1_addr = 24'h000123; p1_wdata = 16'hBEEF; p1_req = 1'b1;
    wait_cmd(n, ok);
    checks++;
    if (!ok || n != 2) begin
      errors++;
      $display("FAIL wr_cmd_latency: got ok=%0d cycles=%0d want ok=1 cycles=2", ok, n);
    end
    checks++;
    if (host_wr_req !== 1'b1 || host_rd_req !== 1'b0 || grant !== 1'b1) begin
      errors++;
      $display("FAIL wr_cmd: got wr=%b rd=%b grant=%b want 1 0 1", host_wr_req, host_rd_req, grant);
    end
    checks++;
    if (host_addr !== 24'h000123 || host_data_in !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_latch: got %h/%h want 000123/beef", host_addr, host_data_in);
    end
    host_busy = 1'b1;
    repeat (3) tick();
    checks++;
    if (p1_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_early_ack: got %b want 0", p1_ack);
    end
    host_busy = 1'b0;
    tick();
    checks++;
    if (p1_ack !== 1'b1 || p0_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: got p1=%b p0=%b want 1 0", p1_ack, p0_ack);
    end
    p1_req = 1'b0;
    tick(); tick();
    checks++;
    if (n_wr - w != 1 || n_ack1 - a1 != 1 || n_ack0 - a0 != 0) begin
      errors++;
      $display("FAIL wr_counts: got wr=%0d ack1=%0d ack0=%0d want 1 1 0",
               n_wr - w, n_ack1 - a1, n_ack0 - a0);
    end
  endtask

  task automatic test_read_p0();
    int n;
    bit ok;
    p0_we = 1'b0; p0_addr = 24'h000123; p0_req = 1'b1;
    wait_cmd(n, ok);
    checks++;
    if (!ok || host_rd_req !== 1'b1 || host_wr_req !== 1'b0 || grant !== 1'b0) begin
      errors++;
      $display("FAIL rd_cmd: got ok=%0d rd=%b wr=%b grant=%b want 1 1 0 0",
               ok, host_rd_req, host_wr_req, grant);
    end
    host_busy = 1'b1;
    tick(); tick();
    host_busy = 1'b0; host_rd_valid = 1'b1; host_data_out = 16'hBEEF;
    checks++;
    if (p0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_ack: got %b want 0", p0_ack);
    end
    tick();
    host_rd_valid = 1'b0; host_data_out = 16'h0;
    checks++;
    if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd_ack: got ack0=%b ack1=%b rdata=%h want 1 0 beef", p0_ack, p1_ack, p0_rdata);
    end
    exp_rd0 = 16'hBEEF;
    checks++;
    if (p1_rdata !== exp_rd1) begin
      errors++;
      $display("FAIL rd_other_port: got %h want %h", p1_rdata, exp_rd1);
    end
    p0_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_refresh_wait();
    int c0, n;
    bit ok;
    host_busy = 1'b1;
    p1_we = 1'b1; p1_addr = 24'h000055; p1_wdata = 16'h1234; p1_req = 1'b1;
    c0 = n_wr + n_rd;
    repeat (10) tick();
    checks++;
    if (n_wr + n_rd - c0 != 0 || host_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL refresh_hold: got %0d cmds want 0", n_wr + n_rd - c0);
    end
    host_busy = 1'b0;
    wait_cmd(n, ok);
    checks++;
    if (!ok || n > 2 || host_addr !== 24'h000055 || grant !== 1'b1) begin
      errors++;
      $display("FAIL refresh_release: got ok=%0d cycles=%0d addr=%h grant=%b want 1 <=2 000055 1",
               ok, n, host_addr, grant);
    end
    host_busy = 1'b1;
    tick();
    host_busy = 1'b0;
    tick();
    checks++;
    if (p1_ack !== 1'b1) begin
      errors++;
      $display("FAIL refresh_ack: got %b want 1", p1_ack);
    end
    p1_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_arbitration();
    logic eg [4];
    int n, b0;
    bit ok;
    logic [DW-1:0] d;
`ifdef SDRAM_ARB_RR_EN
    eg = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    eg = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    b0 = n_both;
    p0_we = 1'b0; p1_we = 1'b0; p0_addr = 24'h000010; p1_addr = 24'h000020;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cmd(n, ok);
      checks++;
      if (!ok || grant !== eg[i] || host_addr !== (eg[i] ? 24'h000020 : 24'h000010)) begin
        errors++;
        $display("FAIL arb_grant%0d: got ok=%0d grant=%b addr=%h want grant=%b", i, ok, grant, host_addr, eg[i]);
      end
      d = 16'hA000 + 16'(i);
      host_rd_valid = 1'b1; host_data_out = d;
      tick();
      host_rd_valid = 1'b0; host_data_out = 16'h0;
      if (eg[i]) exp_rd1 = d;
      else       exp_rd0 = d;
      checks++;
      if (p0_ack !== !eg[i] || p1_ack !== eg[i]) begin
        errors++;
        $display("FAIL arb_ack%0d: got ack0=%b ack1=%b want %b %b", i, p0_ack, p1_ack, !eg[i], eg[i]);
      end
      checks++;
      if (p0_rdata !== exp_rd0 || p1_rdata !== exp_rd1) begin
        errors++;
        $display("FAIL arb_rdata%0d: got %h/%h want %h/%h", i, p0_rdata, p1_rdata, exp_rd0, exp_rd1);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick(); tick();
    checks++;
    if (n_both != b0) begin
      errors++;
      $display("FAIL arb_dual_ack: got %0d cycles with both acks want 0", n_both - b0);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    p0_we = 1'b0; p0_addr = 24'h000077; p0_req = 1'b1;
    wait_cmd(n, ok);
    n = 0;
    while (n < 400 && p0_ack !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (!ok || n != 256) begin
      errors++;
      $display("FAIL tmo_cycles: got ok=%0d cycles=%0d want 1 256", ok, n);
    end
    checks++;
    if (arb_err !== 1'b1 || p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== exp_rd0) begin
      errors++;
      $display("FAIL tmo_ack: got err=%b ack0=%b ack1=%b rdata=%h want 1 1 0 %h",
               arb_err, p0_ack, p1_ack, p0_rdata, exp_rd0);
    end
    p0_req = 1'b0;
    tick();
    checks++;
    if (arb_err !== 1'b0 || p0_ack !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: got err=%b ack0=%b want 0 0", arb_err, p0_ack);
    end
    p0_addr = 24'h000078; p0_req = 1'b1;
    wait_cmd(n, ok);
    host_rd_valid = 1'b1; host_data_out = 16'h4242;
    tick();
    host_rd_valid = 1'b0; host_data_out = 16'h0;
    exp_rd0 = 16'h4242;
    checks++;
    if (!ok || p0_ack !== 1'b1 || arb_err !== 1'b0 || p0_rdata !== exp_rd0) begin
      errors++;
      $display("FAIL tmo_recover: got ok=%0d ack0=%b err=%b rdata=%h want 1 1 0 4242",
               ok, p0_ack, arb_err, p0_rdata);
    end
    p0_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int a, n;
    bit ok;
    p1_we = 1'b0; p1_addr = 24'h000099; p1_req = 1'b1;
    wait_cmd(n, ok);
    host_busy = 1'b1;
    tick(); tick();
    a = n_ack0 + n_ack1;
    rst = 1'b1;
    #1;
    checks++;
    if ({p0_ack, p1_ack, arb_err, host_wr_req, host_rd_req, grant} !== 6'b0 ||
        p0_rdata !== 16'h0 || p1_rdata !== 16'h0 || host_addr !== 24'h0 || host_data_in !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ctrl=%b rdata=%h/%h addr=%h want all zero",
               {p0_ack, p1_ack, arb_err, host_wr_req, host_rd_req, grant}, p0_rdata, p1_rdata, host_addr);
    end
    tick(); tick();
    host_busy = 1'b0; p1_req = 1'b0;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (n_ack0 + n_ack1 != a) begin
      errors++;
      $display("FAIL rst_mid_noack: got %0d acks want 0", n_ack0 + n_ack1 - a);
    end
    p1_we = 1'b1; p1_addr = 24'h000200; p1_wdata = 16'h5A5A; p1_req = 1'b1;
    wait_cmd(n, ok);
    checks++;
    if (!ok || host_wr_req !== 1'b1 || host_addr !== 24'h000200 || host_data_in !== 16'h5A5A) begin
      errors++;
      $display("FAIL rst_post_cmd: got ok=%0d wr=%b addr=%h data=%h want 1 1 000200 5a5a",
               ok, host_wr_req, host_addr, host_data_in);
    end
    host_busy = 1'b1;
    tick();
    host_busy = 1'b0;
    tick();
    checks++;
    if (p1_ack !== 1'b1 || grant !== 1'b1 || arb_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_post_ack: got ack1=%b grant=%b err=%b want 1 1 0", p1_ack, grant, arb_err);
    end
    p1_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_p1();
    test_read_p0();
    test_refresh_wait();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
